timer_counter: RTL and testbench
================================

TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have port DEV_Addr, input, 2, register word select (00 CTRL, 01 PRESET, 10 COUNT, 11 unused).
REQ-004 SHALL have port DEV_Wd, input, 32, write data.
REQ-005 SHALL have port Timer_Wr, input, 1, write strobe, already qualified by address decode.
REQ-006 SHALL have port Timer_Rd, output, 32, combinational read data for DEV_Addr; feeds the bridge DEV1 read input.
REQ-007 SHALL have port Timer_IRQ, output, 1, level interrupt request; feeds bridge HWInt bit 0.

Function
REQ-008 SHALL define CTRL as follows: bit0 Enable, bits[2:1] Mode, bit3 IM (interrupt mask, 1 = allow), bits[31:4] read as 0 and ignore writes.
REQ-009 SHALL define PRESET as 32-bit read/write; COUNT as 32-bit read-only (writes ignored); addr 11 SHALL read 0 and ignore writes.
REQ-010 SHALL decode Mode: 00 = one-shot, 01 = auto-reload, 10/11 = one-shot.
REQ-011 SHALL implement FSM states IDLE, LOAD, CNT, INT.
REQ-012 SHALL transition IDLE -> LOAD when Enable=1; otherwise stay in IDLE.
REQ-013 SHALL, in LOAD, set COUNT <= PRESET and go to CNT.
REQ-014 SHALL, in CNT with Enable=0, go to IDLE and hold COUNT.
REQ-015 SHALL, in CNT with Enable=1 and COUNT<=1, set COUNT <= 0, set irq_pend, and go to INT.
REQ-016 SHALL, in CNT with Enable=1 and COUNT>1, set COUNT <= COUNT-1 (no wrap below 0).
REQ-017 SHALL, in INT, apply mode behaviour: one-shot clears Enable and goes to IDLE; auto-reload goes to LOAD and clears irq_pend.
REQ-018 SHALL drive Timer_IRQ = IM & irq_pend.
REQ-019 SHALL hold irq_pend in one-shot mode until any write to CTRL; in auto-reload, irq_pend is high for exactly the INT cycle.
REQ-020 SHALL have latency such that Timer_IRQ rises PRESET+2 edges after the edge that writes Enable=1 (PRESET=0 behaves as 1), and the auto-reload period is PRESET+2 cycles.
REQ-021 SHALL let a CPU write to CTRL win over the FSM Enable clear in the same cycle.
REQ-022 SHALL let a CPU write to CTRL clear irq_pend in the same cycle that CNT would set it; the set wins, so no interrupt is lost.
REQ-023 SHALL, on a PRESET write during CNT, update PRESET only; COUNT is unaffected until the next LOAD.
REQ-024 SHALL, when Enable is cleared by a write in LOAD or INT, complete that state's action, then reach IDLE from CNT or IDLE on the following cycle.

Reset
REQ-025 SHALL, on reset, set CTRL, PRESET, COUNT, and irq_pend to 0 and the state to IDLE, so Timer_IRQ=0 and all reads return 0.
REQ-026 SHALL give reset priority over Timer_Wr and all FSM activity, including mid-count.

Structure
REQ-027 SHALL place state encodings, register offsets (CTRL/PRESET/COUNT), Mode codes, and CTRL bit positions in shared package timer_defs.
REQ-028 SHALL be a single module with no sub-module; the register file and FSM reside in timer_counter.

Verification
REQ-029 SHALL cover one-shot: PRESET=3, CTRL=0x9 at edge e0 -> COUNT reads 3,2,1,0 at e2..e5; Timer_IRQ=1 from e5; Enable reads 0 after e6; IRQ held until a CTRL write clears it.
REQ-030 SHALL cover auto-reload: PRESET=2, CTRL=0xB -> Timer_IRQ one-cycle pulses every 4 cycles; COUNT reloads to 2 each period.
REQ-031 SHALL cover masking: PRESET=1, CTRL=0x1 (IM=0) -> state reaches INT, Timer_IRQ stays 0; a later write of CTRL=0x8 clears irq_pend, so Timer_IRQ stays 0.
REQ-032 SHALL cover pause: start count PRESET=10, write CTRL=0x8 mid-count at COUNT=6 -> COUNT holds 6, no IRQ; rewriting Enable reloads 10.
REQ-033 SHALL cover register-access edge cases: write COUNT and addr 11 -> no change, reads 0/unchanged; CTRL write 0xFFFFFFFF reads back 0xF.
REQ-034 SHALL cover reset mid-operation: reset asserted at COUNT=5 with IRQ pending -> next cycle all reads 0, Timer_IRQ=0, state IDLE.

Source files
------------

// File: rtl/timer_defs.sv
// rtl/timer_defs.sv - shared definitions for the timer_counter block
// Purpose: FSM state encoding, register word offsets, Mode codes and CTRL
//          bit positions shared by the RTL and anything that decodes it.
// Ports:   none (package).
package timer_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_CNT  = 2'b10,
    ST_INT  = 2'b11
  } state_e;

  // Register word offsets on DEV_Addr
  localparam logic [1:0] ADDR_CTRL   = 2'b00;
  localparam logic [1:0] ADDR_PRESET = 2'b01;
  localparam logic [1:0] ADDR_COUNT  = 2'b10;

  // Mode codes; anything other than auto-reload behaves as one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // CTRL bit positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;
  localparam int CTRL_W        = 4;

  function automatic logic is_auto_reload(input logic [1:0] mode);
    return (mode == MODE_RELOAD);
  endfunction

endpackage

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - programmable down-counting timer with level interrupt
// Purpose: CTRL/PRESET/COUNT register file plus the IDLE/LOAD/CNT/INT FSM that
//          counts COUNT down from PRESET and raises irq_pend on expiry, in
//          one-shot or auto-reload mode.
// Ports:   clk        - clock, all state updates on the rising edge
//          reset      - synchronous active-high reset
//          DEV_Addr   - register word select (CTRL, PRESET, COUNT, unused)
//          DEV_Wd     - write data
//          Timer_Wr   - write strobe, already address-qualified
//          Timer_Rd   - combinational read data for DEV_Addr
//          Timer_IRQ  - level interrupt, IM & irq_pend
module timer_counter
  import timer_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  DEV_Addr,
  input  logic [31:0] DEV_Wd,
  input  logic        Timer_Wr,
  output logic [31:0] Timer_Rd,
  output logic        Timer_IRQ
);

  state_e              state_q, state_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [31:0]         preset_q, preset_d;
  logic [31:0]         count_q, count_d;
  logic                irq_pend_q, irq_pend_d;

  logic                enable;
  logic                ctrl_wr;
  logic                preset_wr;
  logic                fsm_clr_en;
  logic                fsm_set_irq;
  logic                fsm_clr_irq;

  assign enable    = ctrl_q[CTRL_EN_BIT];
  assign ctrl_wr   = Timer_Wr && (DEV_Addr == ADDR_CTRL);
  assign preset_wr = Timer_Wr && (DEV_Addr == ADDR_PRESET);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    fsm_clr_en  = 1'b0;
    fsm_set_irq = 1'b0;
    fsm_clr_irq = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (count_q <= 32'd1) begin
          // PRESET of 0 expires on the same edge as PRESET of 1
          count_d     = 32'd0;
          fsm_set_irq = 1'b1;
          state_d     = ST_INT;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      ST_INT: begin
        if (is_auto_reload(ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB])) begin
          fsm_clr_irq = 1'b1;
          state_d     = ST_LOAD;
        end else begin
          fsm_clr_en = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Register side effects. A CPU CTRL write overrides the FSM's Enable clear,
  // while an FSM irq set overrides the clear implied by a CTRL write so an
  // expiry coinciding with a CTRL write is never dropped.
  always_comb begin
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    irq_pend_d = irq_pend_q;

    if (fsm_clr_en) ctrl_d[CTRL_EN_BIT] = 1'b0;
    if (ctrl_wr)    ctrl_d = DEV_Wd[CTRL_W-1:0];

    if (ctrl_wr || fsm_clr_irq) irq_pend_d = 1'b0;
    if (fsm_set_irq)            irq_pend_d = 1'b1;

    if (preset_wr) preset_d = DEV_Wd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_pend_q <= irq_pend_d;
    end
  end

  always_comb begin
    Timer_Rd = 32'd0;
    unique case (DEV_Addr)
      ADDR_CTRL:   Timer_Rd = {{(32-CTRL_W){1'b0}}, ctrl_q};
      ADDR_PRESET: Timer_Rd = preset_q;
      ADDR_COUNT:  Timer_Rd = count_q;
      default:     Timer_Rd = 32'd0;
    endcase
  end

  assign Timer_IRQ = ctrl_q[CTRL_IM_BIT] & irq_pend_q;

endmodule

// File: tb/tb_timer_counter.sv
// tb/tb_timer_counter.sv - self-checking bench for timer_counter
module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic [1:0]  DEV_Addr;
  logic [31:0] DEV_Wd;
  logic        Timer_Wr;
  logic [31:0] Timer_Rd;
  logic        Timer_IRQ;

  int n_vec;
  int n_bad;

  localparam logic [1:0] A_CTRL   = 2'b00;
  localparam logic [1:0] A_PRESET = 2'b01;
  localparam logic [1:0] A_COUNT  = 2'b10;
  localparam logic [1:0] A_NONE   = 2'b11;

  timer_counter dut (
    .clk       (clk),
    .reset     (reset),
    .DEV_Addr  (DEV_Addr),
    .DEV_Wd    (DEV_Wd),
    .Timer_Wr  (Timer_Wr),
    .Timer_Rd  (Timer_Rd),
    .Timer_IRQ (Timer_IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[22];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    Timer_Wr = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    DEV_Addr = a;
    DEV_Wd   = d;
    Timer_Wr = 1'b1;
    step();
    Timer_Wr = 1'b0;
  endtask

  task automatic idle(input logic [1:0] a);
    DEV_Addr = a;
    Timer_Wr = 1'b0;
    step();
  endtask

  task automatic rd_now(input logic [1:0] a, output logic [31:0] d);
    DEV_Addr = a;
    #1;
    d = Timer_Rd;
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] ar_cnt[12];
    logic [31:0] exp_count;
    logic [31:0] ctrl_m, preset_m, wdata;
    logic [1:0]  addr;
    logic [1:0]  mode;
    logic        im, auto, exp_irq, exp_en, wstb;
    int          p, pe, period, j;

    n_vec    = 0;
    n_bad    = 0;
    reset    = 1'b1;
    DEV_Addr = A_CTRL;
    DEV_Wd   = '0;
    Timer_Wr = 1'b0;

    // Reset state, register edge cases, one-shot with PRESET=0 and PRESET=3
    tbl[0]  = '{1'b0, A_CTRL,   32'h0,        32'h0,    1'b0};
    tbl[1]  = '{1'b0, A_PRESET, 32'h0,        32'h0,    1'b0};
    tbl[2]  = '{1'b0, A_COUNT,  32'h0,        32'h0,    1'b0};
    tbl[3]  = '{1'b0, A_NONE,   32'h0,        32'h0,    1'b0};
    tbl[4]  = '{1'b1, A_CTRL,   32'hFFFFFFFF, 32'hF,    1'b0};
    tbl[5]  = '{1'b0, A_CTRL,   32'h0,        32'hF,    1'b0};
    tbl[6]  = '{1'b0, A_COUNT,  32'h0,        32'h0,    1'b0};
    tbl[7]  = '{1'b0, A_COUNT,  32'h0,        32'h0,    1'b1};
    tbl[8]  = '{1'b0, A_CTRL,   32'h0,        32'hE,    1'b1};
    tbl[9]  = '{1'b1, A_COUNT,  32'h1234,     32'h0,    1'b1};
    tbl[10] = '{1'b1, A_NONE,   32'hDEAD,     32'h0,    1'b1};
    tbl[11] = '{1'b1, A_CTRL,   32'h0,        32'h0,    1'b0};
    tbl[12] = '{1'b1, A_PRESET, 32'h3,        32'h3,    1'b0};
    tbl[13] = '{1'b1, A_CTRL,   32'h9,        32'h9,    1'b0};
    tbl[14] = '{1'b0, A_COUNT,  32'h0,        32'h0,    1'b0};
    tbl[15] = '{1'b0, A_COUNT,  32'h0,        32'h3,    1'b0};
    tbl[16] = '{1'b0, A_COUNT,  32'h0,        32'h2,    1'b0};
    tbl[17] = '{1'b0, A_COUNT,  32'h0,        32'h1,    1'b0};
    tbl[18] = '{1'b0, A_COUNT,  32'h0,        32'h0,    1'b1};
    tbl[19] = '{1'b0, A_CTRL,   32'h0,        32'h8,    1'b1};
    tbl[20] = '{1'b0, A_CTRL,   32'h0,        32'h8,    1'b1};
    tbl[21] = '{1'b1, A_CTRL,   32'h8,        32'h8,    1'b0};

    do_reset();
    for (int i = 0; i < 22; i++) begin
      DEV_Addr = tbl[i].addr;
      DEV_Wd   = tbl[i].wd;
      Timer_Wr = tbl[i].wr;
      step();
      Timer_Wr = 1'b0;
      chk($sformatf("tbl%0d_rd", i), Timer_Rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_irq", i), {31'd0, Timer_IRQ}, {31'd0, tbl[i].exp_irq});
    end

    // Auto-reload PRESET=2: one-cycle pulse every 4 cycles, COUNT reloads to 2
    ar_cnt = '{32'd0, 32'd2, 32'd1, 32'd0, 32'd0, 32'd2, 32'd1, 32'd0,
               32'd0, 32'd2, 32'd1, 32'd0};
    do_reset();
    wr(A_PRESET, 32'd2);
    wr(A_CTRL, 32'hB);
    for (int k = 1; k <= 12; k++) begin
      idle(A_COUNT);
      chk($sformatf("ar_count_k%0d", k), Timer_Rd, ar_cnt[k-1]);
      chk($sformatf("ar_irq_k%0d", k), {31'd0, Timer_IRQ},
          {31'd0, (k == 4 || k == 8 || k == 12)});
    end

    // Masked expiry: irq never visible, Enable still self-clears
    do_reset();
    wr(A_PRESET, 32'd1);
    wr(A_CTRL, 32'h1);
    for (int k = 1; k <= 5; k++) begin
      idle(A_CTRL);
      chk($sformatf("mask_irq_k%0d", k), {31'd0, Timer_IRQ}, 32'd0);
    end
    chk("mask_ctrl_after", Timer_Rd, 32'h0);
    wr(A_CTRL, 32'h8);
    chk("mask_ctrl_im", Timer_Rd, 32'h8);
    chk("mask_irq_after_im", {31'd0, Timer_IRQ}, 32'd0);
    idle(A_CTRL);
    chk("mask_irq_later", {31'd0, Timer_IRQ}, 32'd0);

    // Pause at COUNT=6, then re-enable reloads PRESET
    do_reset();
    wr(A_PRESET, 32'd10);
    wr(A_CTRL, 32'h9);
    for (int k = 1; k <= 5; k++) idle(A_COUNT);
    chk("pause_count7", Timer_Rd, 32'd7);
    wr(A_CTRL, 32'h8);
    DEV_Addr = A_COUNT;
    #1;
    chk("pause_count6", Timer_Rd, 32'd6);
    for (int k = 0; k < 4; k++) begin
      idle(A_COUNT);
      chk($sformatf("pause_hold%0d", k), Timer_Rd, 32'd6);
      chk($sformatf("pause_irq%0d", k), {31'd0, Timer_IRQ}, 32'd0);
    end
    wr(A_CTRL, 32'h9);
    idle(A_COUNT);
    idle(A_COUNT);
    chk("pause_reload", Timer_Rd, 32'd10);

    // CTRL write on the expiry edge: set wins, then reset clears pending irq
    do_reset();
    wr(A_PRESET, 32'd1);
    wr(A_CTRL, 32'h9);
    idle(A_COUNT);
    idle(A_COUNT);
    chk("race_count1", Timer_Rd, 32'd1);
    wr(A_CTRL, 32'h9);
    chk("race_irq_kept", {31'd0, Timer_IRQ}, 32'd1);
    idle(A_CTRL);
    chk("race_en_cleared", Timer_Rd, 32'h8);
    chk("race_irq_held", {31'd0, Timer_IRQ}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("race_reset_irq", {31'd0, Timer_IRQ}, 32'd0);

    // Reset mid-count with a simultaneous PRESET write
    do_reset();
    wr(A_PRESET, 32'd10);
    wr(A_CTRL, 32'h9);
    for (int k = 1; k <= 7; k++) idle(A_COUNT);
    chk("rst_pre_count5", Timer_Rd, 32'd5);
    reset    = 1'b1;
    DEV_Addr = A_PRESET;
    DEV_Wd   = 32'h55;
    Timer_Wr = 1'b1;
    step();
    reset    = 1'b0;
    Timer_Wr = 1'b0;
    rd_now(A_CTRL, r);   chk("rst_ctrl", r, 32'h0);
    rd_now(A_PRESET, r); chk("rst_preset", r, 32'h0);
    rd_now(A_COUNT, r);  chk("rst_count", r, 32'h0);
    rd_now(A_NONE, r);   chk("rst_none", r, 32'h0);
    chk("rst_irq", {31'd0, Timer_IRQ}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      idle(A_COUNT);
      chk($sformatf("rst_idle%0d", k), Timer_Rd, 32'd0);
    end

    // Randomized runs against an arithmetic model of the countdown schedule
    for (int run = 0; run < 16; run++) begin
      p      = int'($urandom_range(0, 12));
      mode   = 2'($urandom_range(0, 3));
      im     = 1'($urandom_range(0, 1));
      auto   = (mode == 2'b01);
      pe     = (p == 0) ? 1 : p;
      period = pe + 2;
      do_reset();
      wr(A_PRESET, 32'(p));
      wr(A_CTRL, {28'd0, im, mode, 1'b1});
      for (int k = 1; k <= 3 * period + 2; k++) begin
        if (k < 2) begin
          exp_count = 32'd0;
          exp_irq   = 1'b0;
        end else if (auto) begin
          j         = (k - 2) % period;
          exp_count = (p > j) ? 32'(p - j) : 32'd0;
          exp_irq   = im && (j == pe);
        end else begin
          exp_count = (p > k - 2) ? 32'(p - (k - 2)) : 32'd0;
          exp_irq   = im && (k >= pe + 2);
        end
        exp_en = auto || (k <= pe + 2);
        if (k % 2 == 1) begin
          idle(A_COUNT);
          chk($sformatf("rnd%0d_p%0d_m%0d_count_k%0d", run, p, mode, k), Timer_Rd, exp_count);
        end else begin
          idle(A_CTRL);
          chk($sformatf("rnd%0d_p%0d_m%0d_ctrl_k%0d", run, p, mode, k), Timer_Rd,
              {28'd0, im, mode, exp_en});
        end
        chk($sformatf("rnd%0d_p%0d_m%0d_irq_k%0d", run, p, mode, k),
            {31'd0, Timer_IRQ}, {31'd0, exp_irq});
      end
    end

    // Randomized register traffic with the timer kept disabled
    do_reset();
    ctrl_m   = 32'd0;
    preset_m = 32'd0;
    for (int i = 0; i < 40; i++) begin
      addr  = 2'($urandom_range(0, 3));
      wdata = $urandom();
      wstb  = 1'($urandom_range(0, 1));
      if (addr == A_CTRL) wdata[0] = 1'b0;
      if (wstb && addr == A_CTRL)   ctrl_m   = {28'd0, wdata[3:0]};
      if (wstb && addr == A_PRESET) preset_m = wdata;
      DEV_Addr = addr;
      DEV_Wd   = wdata;
      Timer_Wr = wstb;
      step();
      Timer_Wr = 1'b0;
      case (addr)
        A_CTRL:   chk($sformatf("reg%0d_ctrl", i), Timer_Rd, ctrl_m);
        A_PRESET: chk($sformatf("reg%0d_preset", i), Timer_Rd, preset_m);
        default:  chk($sformatf("reg%0d_a%0d", i, addr), Timer_Rd, 32'd0);
      endcase
      chk($sformatf("reg%0d_irq", i), {31'd0, Timer_IRQ}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
